// File: rtl/writeback_unit.sv
// writeback_unit: register-file write port producer.
// Merges queued ALU results with one outstanding memory load. The load
// result always wins the write port. Also tracks the pending load destination
// for hazard detection and keeps a sticky protocol/format error flag.
module writeback_unit #(
  parameter int DWIDTH     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid_i,
  output logic              alu_ready_o,
  input  logic [4:0]        alu_rd_i,
  input  logic [DWIDTH-1:0] alu_data_i,
  input  logic              ld_req_valid_i,
  output logic              ld_req_ready_o,
  input  logic [4:0]        ld_req_rd_i,
  input  logic [2:0]        ld_req_funct3_i,
  input  logic [1:0]        ld_req_addr_lo_i,
  input  logic              mem_rsp_valid_i,
  input  logic [31:0]       mem_rsp_data_i,
  output logic [4:0]        rd_o,
  output logic [DWIDTH-1:0] datawb_o,
  output logic              regwren_o,
  output logic [31:0]       pending_o,
  output logic              err_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   C_DEPTH   = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   C_CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] C_PTR_ONE = PW'(1);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WAIT_RSP   = 2'd1;
  localparam logic [1:0] S_WRITE_LOAD = 2'd2;

  logic [1:0]        r_state;
  logic [4:0]        r_ld_rd;
  logic [2:0]        r_ld_f3;
  logic [1:0]        r_ld_lo;
  logic [DWIDTH-1:0] r_ld_data;
  logic [31:0]       r_pending;
  logic              r_err;

  logic [4:0]        r_fifo_rd   [FIFO_DEPTH];
  logic [DWIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [PW:0]       r_count;

  logic [4:0]        r_rd;
  logic [DWIDTH-1:0] r_data;
  logic              r_wren;

  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_ld_write;
  logic              w_rsp_take;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DWIDTH-1:0] w_fmt;
  logic              w_fmt_err;

  assign w_full      = (r_count == C_DEPTH);
  assign alu_ready_o = !w_full;
  // rd=0 results are handshaken away but never occupy a slot.
  assign w_push      = alu_valid_i && !w_full && (alu_rd_i != 5'd0);
  assign w_ld_write  = (r_state == S_WRITE_LOAD) && (r_ld_rd != 5'd0);
  assign w_pop       = !w_ld_write && (r_count != '0);
  assign w_rsp_take  = (r_state == S_WAIT_RSP) && mem_rsp_valid_i;

  assign ld_req_ready_o = (r_state == S_IDLE);
  assign rd_o           = r_rd;
  assign datawb_o       = r_data;
  assign regwren_o      = r_wren;
  assign pending_o      = r_pending;
  assign err_o          = r_err;

  // Select and extend the addressed byte/half of the raw memory word.
  always_comb begin
    w_fmt     = '0;
    w_fmt_err = 1'b0;
    w_half    = r_ld_lo[1] ? mem_rsp_data_i[31:16] : mem_rsp_data_i[15:0];
    case (r_ld_lo)
      2'd0:    w_byte = mem_rsp_data_i[7:0];
      2'd1:    w_byte = mem_rsp_data_i[15:8];
      2'd2:    w_byte = mem_rsp_data_i[23:16];
      default: w_byte = mem_rsp_data_i[31:24];
    endcase
    case (r_ld_f3)
      3'b000:  w_fmt = {{(DWIDTH-8){w_byte[7]}}, w_byte};
      3'b100:  w_fmt = {{(DWIDTH-8){1'b0}}, w_byte};
      3'b001:  w_fmt = {{(DWIDTH-16){w_half[15]}}, w_half};
      3'b101:  w_fmt = {{(DWIDTH-16){1'b0}}, w_half};
      3'b010:  w_fmt = DWIDTH'(mem_rsp_data_i);
      default: w_fmt_err = 1'b1;
    endcase
  end

  // Load tracker FSM, pending scoreboard and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ld_rd   <= '0;
      r_ld_f3   <= '0;
      r_ld_lo   <= '0;
      r_ld_data <= '0;
      r_pending <= '0;
      r_err     <= 1'b0;
    end else begin
      if (mem_rsp_valid_i && (r_state != S_WAIT_RSP)) r_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (ld_req_valid_i) begin
            r_ld_rd <= ld_req_rd_i;
            r_ld_f3 <= ld_req_funct3_i;
            r_ld_lo <= ld_req_addr_lo_i;
            if (ld_req_rd_i != 5'd0) r_pending[ld_req_rd_i] <= 1'b1;
            r_state <= S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          if (w_rsp_take) begin
            r_ld_data <= w_fmt;
            if (w_fmt_err) r_err <= 1'b1;
            r_state <= S_WRITE_LOAD;
          end
        end
        S_WRITE_LOAD: begin
          r_pending[r_ld_rd] <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ALU queue storage; contents need no reset because count gates use.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= alu_rd_i;
      r_fifo_data[r_wptr] <= alu_data_i;
    end
  end

  // ALU queue pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + C_PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + C_PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + C_CNT_ONE;
      else if (!w_push && w_pop) r_count <= r_count - C_CNT_ONE;
    end
  end

  // Registered write port: load result first, else queue head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd   <= '0;
      r_data <= '0;
      r_wren <= 1'b0;
    end else if (w_ld_write) begin
      r_rd   <= r_ld_rd;
      r_data <= r_ld_data;
      r_wren <= 1'b1;
    end else if (w_pop) begin
      r_rd   <= r_fifo_rd[r_rptr];
      r_data <= r_fifo_data[r_rptr];
      r_wren <= 1'b1;
    end else begin
      r_wren <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed stimulus with a write-port scoreboard.
// Stimulus pushes expected register writes into a queue; an independent
// monitor pops and compares on every regwren_o pulse.
module tb_writeback_unit;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid_i = 1'b0;
  logic        alu_ready_o;
  logic [4:0]  alu_rd_i = '0;
  logic [31:0] alu_data_i = '0;
  logic        ld_req_valid_i = 1'b0;
  logic        ld_req_ready_o;
  logic [4:0]  ld_req_rd_i = '0;
  logic [2:0]  ld_req_funct3_i = '0;
  logic [1:0]  ld_req_addr_lo_i = '0;
  logic        mem_rsp_valid_i = 1'b0;
  logic [31:0] mem_rsp_data_i = '0;
  logic [4:0]  rd_o;
  logic [31:0] datawb_o;
  logic        regwren_o;
  logic [31:0] pending_o;
  logic        err_o;

  int n_checks = 0;
  int n_fail   = 0;
  wr_t exp_q[$];

  writeback_unit #(.DWIDTH(32), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
    .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .ld_req_valid_i(ld_req_valid_i), .ld_req_ready_o(ld_req_ready_o),
    .ld_req_rd_i(ld_req_rd_i), .ld_req_funct3_i(ld_req_funct3_i),
    .ld_req_addr_lo_i(ld_req_addr_lo_i),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
    .rd_o(rd_o), .datawb_o(datawb_o), .regwren_o(regwren_o),
    .pending_o(pending_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input logic [4:0] rd, input logic [31:0] data);
    wr_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Offer one ALU result and hold it until accepted (bounded).
  task automatic alu_send(input logic [4:0] rd, input logic [31:0] data);
    logic ok;
    alu_valid_i = 1'b1;
    alu_rd_i    = rd;
    alu_data_i  = data;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      ok = alu_ready_o;
      if (ok && rd != 5'd0) exp_push(rd, data);
      tick();
    end
    alu_valid_i = 1'b0;
    if (!ok) chk("alu_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic ld_issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
    logic ok;
    ld_req_valid_i   = 1'b1;
    ld_req_rd_i      = rd;
    ld_req_funct3_i  = f3;
    ld_req_addr_lo_i = lo;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      ok = ld_req_ready_o;
      tick();
    end
    ld_req_valid_i = 1'b0;
    if (!ok) chk("ld_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic mem_rsp(input logic [31:0] word);
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = word;
    tick();
    mem_rsp_valid_i = 1'b0;
  endtask

  // Monitor: every write-port pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && regwren_o) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got x%0d=0x%08h expected no write", rd_o, datawb_o);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (rd_o !== e.rd || datawb_o !== e.data) begin
          n_fail++;
          $display("FAIL wb_write: got x%0d=0x%08h expected x%0d=0x%08h", rd_o, datawb_o, e.rd, e.data);
        end else begin
          $display("ok   wb_write: x%0d=0x%08h", rd_o, datawb_o);
        end
      end
    end
  end

  // Load formatting vectors: funct3, addr_lo, raw word, expected result.
  logic [2:0]  v_f3  [6] = '{3'b000, 3'b101, 3'b010, 3'b001, 3'b100, 3'b001};
  logic [1:0]  v_lo  [6] = '{2'd2, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0};
  logic [31:0] v_raw [6] = '{32'h0080_0000, 32'h8001_1234, 32'h8001_1234,
                             32'h8001_1234, 32'h8001_1234, 32'h0000_F234};
  logic [31:0] v_exp [6] = '{32'hFFFF_FF80, 32'h0000_8001, 32'h8001_1234,
                             32'hFFFF_8001, 32'h0000_0012, 32'hFFFF_F234};

  initial begin
    #12;
    chk("reset_regwren", {31'd0, regwren_o}, 32'd0);
    chk("reset_rd_data", {27'd0, rd_o} | datawb_o, 32'd0);
    chk("reset_pending", pending_o, 32'd0);
    chk("reset_readys", {30'd0, ld_req_ready_o, alu_ready_o}, 32'd3);
    chk("reset_err", {31'd0, err_o}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // ALU stream, including a discarded rd=0 result.
    alu_send(5'd5, 32'h0000_000A);
    alu_send(5'd6, 32'h0000_000B);
    alu_send(5'd0, 32'hDEAD_BEEF);
    tick(); tick();

    // Load formatting; first vector is the LB rd=7 scenario.
    for (int i = 0; i < 6; i++) begin
      ld_issue(5'd7, v_f3[i], v_lo[i]);
      chk("ld_pending_set", pending_o, 32'h0000_0080);
      chk("ld_ready_wait", {31'd0, ld_req_ready_o}, 32'd0);
      tick();
      exp_push(5'd7, v_exp[i]);
      mem_rsp(v_raw[i]);
      chk("ld_ready_writeload", {31'd0, ld_req_ready_o}, 32'd0);
      tick();
      chk("ld_pending_clear", pending_o, 32'd0);
      chk("ld_ready_idle", {31'd0, ld_req_ready_o}, 32'd1);
    end
    chk("ld_err_clean", {31'd0, err_o}, 32'd0);

    // Load to x0: full sequence, no pending bit, no write.
    ld_issue(5'd0, 3'b010, 2'd0);
    chk("ld_x0_pending", pending_o, 32'd0);
    mem_rsp(32'h1234_5678);
    tick(); tick();

    // Priority and backpressure.
    ld_issue(5'd9, 3'b010, 2'd0);
    exp_push(5'd9, 32'hCAFE_0009);
    exp_push(5'd3, 32'h0000_0033);
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'hCAFE_0009;
    alu_valid_i = 1'b1; alu_rd_i = 5'd3; alu_data_i = 32'h0000_0033;
    chk("prio_ready_x3", {31'd0, alu_ready_o}, 32'd1);
    tick();
    mem_rsp_valid_i = 1'b0;
    exp_push(5'd4, 32'h0000_0044);
    alu_rd_i = 5'd4; alu_data_i = 32'h0000_0044;
    chk("prio_ready_x4", {31'd0, alu_ready_o}, 32'd1);
    tick();
    alu_rd_i = 5'd8; alu_data_i = 32'h0000_0088;
    chk("prio_full_ready", {31'd0, alu_ready_o}, 32'd0);
    tick();
    chk("prio_slot_free", {31'd0, alu_ready_o}, 32'd1);
    exp_push(5'd8, 32'h0000_0088);
    tick();
    alu_valid_i = 1'b0;
    tick(); tick(); tick();

    // Bad funct3: zero written, sticky error.
    ld_issue(5'd10, 3'b011, 2'd0);
    exp_push(5'd10, 32'd0);
    mem_rsp(32'hFFFF_FFFF);
    chk("badf3_err", {31'd0, err_o}, 32'd1);
    tick(); tick();
    chk("badf3_err_sticky", {31'd0, err_o}, 32'd1);

    // Reset clears error; then a stray response in IDLE.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    chk("rst_err_clear", {31'd0, err_o}, 32'd0);
    mem_rsp(32'h5555_5555);
    chk("stray_err", {31'd0, err_o}, 32'd1);
    tick(); tick();

    // Produce a non-zero write port, then reset asynchronously in WAIT_RSP.
    alu_send(5'd11, 32'h0000_0BBB);
    tick();
    ld_issue(5'd12, 3'b010, 2'd0);
    chk("arst_pre_pending", pending_o, 32'h0000_1000);
    #2 rst = 1'b1;
    #1;
    chk("arst_rd_data", {27'd0, rd_o} | datawb_o, 32'd0);
    chk("arst_pending", pending_o, 32'd0);
    chk("arst_err_wren", {30'd0, err_o, regwren_o}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_idle_ready", {31'd0, ld_req_ready_o}, 32'd1);
    mem_rsp(32'h0000_0001);
    chk("arst_stray_err", {31'd0, err_o}, 32'd1);
    tick(); tick();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
